// File: rtl/alu_flag_writeback_if.sv
// Execute-stage outcome bus plus register-file writeback port for alu_flag_writeback.
//   master : execute stage / register file side (drives in_*, flush, wb_ready)
//   slave  : alu_flag_writeback (drives in_ready, carry/zero flags, wb_valid/addr/data)
interface alu_flag_writeback_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_carry;
  logic              in_modify_reg_write;
  logic [2:0]        in_alu_control;
  logic [ADDR_W-1:0] in_rd;
  logic              in_reg_write;
  logic              in_is_load;
  logic [DATA_W-1:0] in_load_data;
  logic              carry_flag;
  logic              zero_flag;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, flush, in_result, in_zero, in_carry, in_modify_reg_write,
           in_alu_control, in_rd, in_reg_write, in_is_load, in_load_data, wb_ready,
    input  in_ready, carry_flag, zero_flag, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, flush, in_result, in_zero, in_carry, in_modify_reg_write,
           in_alu_control, in_rd, in_reg_write, in_is_load, in_load_data, wb_ready,
    output in_ready, carry_flag, zero_flag, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_flag_writeback.sv
// Consumer end of the execute-stage ALU interface.
// Captures each ALU/load outcome, maintains the architectural C and Z flags (fed back to
// the ALU), resolves conditional-write suppression and queues register-file writes in a
// small FIFO drained through a ready/valid writeback port.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_flag_writeback_if.slave (execute outcome in, flags out, writeback out)
module alu_flag_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input logic             clk,
  input logic             reset_n,
  alu_flag_writeback_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpAdz = 3'b001,
    OpAdc = 3'b010,
    OpAdl = 3'b011,
    OpNdu = 3'b100,
    OpNdz = 3'b101,
    OpNdc = 3'b110,
    OpSub = 3'b111
  } alu_op_e;

  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic in_ready;
  logic wb_valid;
  logic accept;
  logic eff_write;
  logic push;
  logic pop;

  // Ready depends on registered occupancy only, never on wb_ready.
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign wb_valid  = (count_q != '0);
  assign accept    = bus.in_valid & in_ready & ~bus.flush;
  // Loads always write; a failed ALU condition suppresses the write.
  assign eff_write = bus.in_reg_write & (bus.in_is_load | ~bus.in_modify_reg_write);
  assign push      = accept & eff_write;
  assign pop       = wb_valid & bus.wb_ready;

  // Flag next-state
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (accept) begin
      if (bus.in_is_load) begin
        zero_d = (bus.in_load_data == '0);
      end else begin
        case (bus.in_alu_control)
          OpAdd, OpAdl: begin
            carry_d = bus.in_carry;
            zero_d  = bus.in_zero;
          end
          OpAdc, OpAdz: begin
            if (!bus.in_modify_reg_write) begin
              carry_d = bus.in_carry;
              zero_d  = bus.in_zero;
            end
          end
          OpNdu: zero_d = bus.in_zero;
          OpNdc, OpNdz: begin
            if (!bus.in_modify_reg_write) zero_d = bus.in_zero;
          end
          OpSub: ; // compare only
          default: ;
        endcase
      end
    end
  end

  // FIFO pointer / occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.in_rd;
      data_mem_q[wr_ptr_q] <= bus.in_is_load ? bus.in_load_data : bus.in_result;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_addr    = addr_mem_q[rd_ptr_q];
  assign bus.wb_data    = data_mem_q[rd_ptr_q];

endmodule
